// File: rtl/inv_cal_sampler.sv
// inv_cal_sampler: majority-vote step decision for an inverter-pair calibration loop.
// Optional lock detection is enabled by defining CAL_LOCK_DETECT_EN.
module inv_cal_sampler #(
  parameter int WIN_BITS   = 4,
  parameter int SETTLE_CYC = 8,
  parameter int LOCK_CNT   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic raw_cmp,
  output logic o_invu,
  output logic o_invd,
  output logic step,
  output logic busy,
  output logic locked
);

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, DECIDE, DONE} state_t;

  localparam logic [7:0]          SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [WIN_BITS-1:0] SAMP_LAST   = {WIN_BITS{1'b1}};
  localparam logic [WIN_BITS:0]   HALF        = (WIN_BITS + 1)'(2 ** (WIN_BITS - 1));
  localparam logic [3:0]          LOCK_MAX    = 4'(LOCK_CNT);

  state_t              state_reg, state_next;
  logic                sync1_reg, sync2_reg;
  logic [7:0]          settle_cnt_reg, settle_cnt_next;
  logic [WIN_BITS-1:0] samp_cnt_reg, samp_cnt_next;
  logic [WIN_BITS:0]   ones_reg, ones_next;
  logic                invu_reg, invu_next;
  logic                invd_reg, invd_next;
  logic                step_reg, step_next;
  logic [3:0]          rev_reg, rev_next;
  logic                prev_valid_reg, prev_valid_next;
  logic                prev_up_reg, prev_up_next;
`ifdef CAL_LOCK_DETECT_EN
  logic                locked_reg, locked_next;
`endif

  logic dec_up, dec_dn;
  logic [3:0] rev_inc;

  assign dec_up  = (ones_reg > HALF);
  assign dec_dn  = (ones_reg < HALF);
  // Saturate so a long reversal run can never wrap back below the lock threshold.
  assign rev_inc = (rev_reg == LOCK_MAX) ? rev_reg : rev_reg + 4'd1;

  always_comb begin
    state_next      = state_reg;
    settle_cnt_next = settle_cnt_reg;
    samp_cnt_next   = samp_cnt_reg;
    ones_next       = ones_reg;
    invu_next       = invu_reg;
    invd_next       = invd_reg;
    step_next       = 1'b0;
    rev_next        = rev_reg;
    prev_valid_next = prev_valid_reg;
    prev_up_next    = prev_up_reg;
`ifdef CAL_LOCK_DETECT_EN
    locked_next     = locked_reg;
`endif

    if (!start) begin
      state_next      = IDLE;
      settle_cnt_next = 8'd0;
      samp_cnt_next   = '0;
      ones_next       = '0;
      invu_next       = 1'b0;
      invd_next       = 1'b0;
      rev_next        = 4'd0;
      prev_valid_next = 1'b0;
      prev_up_next    = 1'b0;
`ifdef CAL_LOCK_DETECT_EN
      locked_next     = 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          state_next      = SETTLE;
          settle_cnt_next = 8'd0;
        end
        SETTLE: begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            state_next    = SAMPLE;
            samp_cnt_next = '0;
            ones_next     = '0;
          end else begin
            settle_cnt_next = settle_cnt_reg + 8'd1;
          end
        end
        SAMPLE: begin
          ones_next = ones_reg + (WIN_BITS + 1)'(sync2_reg);
          if (samp_cnt_reg == SAMP_LAST) begin
            state_next = DECIDE;
          end else begin
            samp_cnt_next = samp_cnt_reg + WIN_BITS'(1);
          end
        end
        DECIDE: begin
          state_next      = SETTLE;
          settle_cnt_next = 8'd0;
          invu_next       = dec_up;
          invd_next       = dec_dn;
          step_next       = dec_up | dec_dn;
          // Hold decisions neither count nor break a reversal run.
          if (dec_up | dec_dn) begin
            if (prev_valid_reg && (prev_up_reg != dec_up)) begin
              rev_next = rev_inc;
            end else begin
              rev_next = 4'd0;
            end
            prev_valid_next = 1'b1;
            prev_up_next    = dec_up;
          end
`ifdef CAL_LOCK_DETECT_EN
          if (rev_next >= LOCK_MAX) begin
            state_next  = DONE;
            invu_next   = 1'b0;
            invd_next   = 1'b0;
            step_next   = 1'b0;
            locked_next = 1'b1;
          end
`endif
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      sync1_reg      <= 1'b0;
      sync2_reg      <= 1'b0;
      settle_cnt_reg <= 8'd0;
      samp_cnt_reg   <= '0;
      ones_reg       <= '0;
      invu_reg       <= 1'b0;
      invd_reg       <= 1'b0;
      step_reg       <= 1'b0;
      rev_reg        <= 4'd0;
      prev_valid_reg <= 1'b0;
      prev_up_reg    <= 1'b0;
`ifdef CAL_LOCK_DETECT_EN
      locked_reg     <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      sync1_reg      <= raw_cmp;
      sync2_reg      <= sync1_reg;
      settle_cnt_reg <= settle_cnt_next;
      samp_cnt_reg   <= samp_cnt_next;
      ones_reg       <= ones_next;
      invu_reg       <= invu_next;
      invd_reg       <= invd_next;
      step_reg       <= step_next;
      rev_reg        <= rev_next;
      prev_valid_reg <= prev_valid_next;
      prev_up_reg    <= prev_up_next;
`ifdef CAL_LOCK_DETECT_EN
      locked_reg     <= locked_next;
`endif
    end
  end

  assign o_invu = invu_reg;
  assign o_invd = invd_reg;
  assign step   = step_reg;
  assign busy   = (state_reg != IDLE) && (state_reg != DONE);
`ifdef CAL_LOCK_DETECT_EN
  assign locked = locked_reg;
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_inv_cal_sampler.sv
// Scoreboard bench for inv_cal_sampler: per-window patterns are driven in step with the
// sampling window and the expected decision is queued, then compared after DECIDE exits.
module tb_inv_cal_sampler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic raw_cmp = 1'b0;
  logic o_invu, o_invd, step, busy, locked;

  localparam int LOCK_N = 4;

  inv_cal_sampler #(.WIN_BITS(4), .SETTLE_CYC(8), .LOCK_CNT(LOCK_N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .raw_cmp(raw_cmp),
    .o_invu(o_invu), .o_invd(o_invd), .step(step), .busy(busy), .locked(locked)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // {o_invu, o_invd, step, locked, busy}
  logic [4:0] sb[$];

  logic [1:0] ref_out;
  logic       ref_valid, ref_up, ref_locked;
  int         ref_rev;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    ref_out    = 2'b00;
    ref_valid  = 1'b0;
    ref_up     = 1'b0;
    ref_rev    = 0;
    ref_locked = 1'b0;
  endtask

  // Entered just after the edge that starts SETTLE; returns just after the edge leaving DECIDE.
  task automatic run_window(input logic [15:0] pat);
    int         ones;
    logic [1:0] dec;
    logic [1:0] old_out;
    logic       old_locked;
    logic [4:0] exp;
    logic [4:0] got;
    ones       = $countones(pat);
    dec        = (ones > 8) ? 2'b10 : ((ones < 8) ? 2'b01 : 2'b00);
    old_out    = ref_out;
    old_locked = ref_locked;
    if (ref_locked) begin
      exp = 5'b00010;
    end else begin
      if (dec != 2'b00) begin
        if (ref_valid && (ref_up != dec[1])) ref_rev = ref_rev + 1;
        else ref_rev = 0;
        ref_valid = 1'b1;
        ref_up    = dec[1];
      end
      exp     = {dec, (dec != 2'b00), 1'b0, 1'b1};
      ref_out = dec;
`ifdef CAL_LOCK_DETECT_EN
      if (ref_rev >= LOCK_N) begin
        ref_locked = 1'b1;
        ref_out    = 2'b00;
        exp        = 5'b00010;
      end
`endif
    end
    sb.push_back(exp);
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      if (j >= 6 && j <= 21) raw_cmp = pat[j-6];
      @(posedge clk);
      #1;
      if (j == 0) chk("pulse_end", {6'd0, busy, step}, {6'd0, !old_locked, 1'b0});
      if (j == 23) chk("hold", {6'd0, o_invu, o_invd}, {6'd0, old_out});
    end
    got = {o_invu, o_invd, step, locked, busy};
    if (sb.size() == 0) begin
      chk("sb_empty", 8'd1, 8'd0);
    end else begin
      exp = sb.pop_front();
      chk($sformatf("dec_%04h", pat), {3'd0, got}, {3'd0, exp});
    end
  endtask

  task automatic stop_restart();
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("stop", {3'd0, o_invu, o_invd, step, busy, locked}, 8'd0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    model_clear();
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset", {3'd0, o_invu, o_invd, step, busy, locked}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);

    // Constant-high comparator, then boundary counts around the 8-of-16 midpoint.
    run_window(16'hFFFF);
    run_window(16'hFFFF);
    run_window(16'hFFFF);
    run_window(16'hAAAA);
    run_window(16'h0000);
    run_window(16'h00FF);
    run_window(16'h0001);
    run_window(16'hFFFE);
    run_window(16'h01FF);
    run_window(16'h007F);
    run_window(16'h8001);

    // START dropped during SETTLE, then a fresh full-length period.
    stop_restart();
    run_window(16'hFFFF);

    // Asynchronous reset in the middle of a sampling window.
    repeat (15) @(posedge clk);
    #1;
    chk("pre_arst", {7'd0, o_invu}, 8'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst", {3'd0, o_invu, o_invd, step, busy, locked}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_after_rst", {7'd0, busy}, 8'd0);
    @(posedge clk);
    model_clear();
    run_window(16'h0000);
    run_window(16'h5555);

    // Window-by-window alternation; locks only when lock detection is built in.
    stop_restart();
    run_window(16'hFFFF);
    run_window(16'h0000);
    run_window(16'hFFFF);
    run_window(16'h0000);
    run_window(16'hFFFF);
    run_window(16'h0000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/inv_cal_sampler.md
INV_CAL_SAMPLER -- requirements
Module: inv_cal_sampler

Interface
REQ-001 The block SHALL provide parameter WIN_BITS, default 4, meaning log2 of samples per decision window (window = 2^WIN_BITS).
REQ-002 The block SHALL provide parameter SETTLE_CYC, default 8, meaning idle cycles after each decision before sampling resumes (range 1..255).
REQ-003 The block SHALL provide parameter LOCK_CNT, default 4, meaning consecutive direction reversals that declare lock (range 1..15).
REQ-004 The block SHALL provide CLK  input  1  single clock for all state, rising edge.
REQ-005 The block SHALL provide RST_N  input  1  reset, asynchronous assert, active-low.
REQ-006 The block SHALL provide START  input  1  level enable of calibration; low forces IDLE.
REQ-007 The block SHALL provide RAW_CMP  input  1  asynchronous comparator output of the inverter pair (1 = up side strong).
REQ-008 The block SHALL provide O_INVU  output  1  registered decision "step up", consumed by the downstream CONF block.
REQ-009 The block SHALL provide O_INVD  output  1  registered decision "step down", consumed by the downstream CONF block.
REQ-010 The block SHALL provide STEP  output  1  one-cycle pulse marking a new non-hold decision.
REQ-011 The block SHALL provide BUSY  output  1  high in every state except IDLE and DONE.
REQ-012 The block SHALL provide LOCKED  output  1  lock indication.

Function
REQ-013 RAW_CMP SHALL pass through a 2-flop synchronizer; only the second flop SHALL be used.
REQ-014 The FSM SHALL have states IDLE, SETTLE, SAMPLE, DECIDE, DONE.
REQ-015 IDLE->SETTLE SHALL occur on the first clock edge with START=1; any state->IDLE SHALL occur on the first edge with START=0, clearing O_INVU, O_INVD, STEP, reversal count and LOCKED.
REQ-016 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to SAMPLE.
REQ-017 SAMPLE SHALL last exactly 2^WIN_BITS cycles, adding the synchronized bit to a ones counter WIN_BITS+1 bits wide (no saturation needed; max equals 2^WIN_BITS), then go to DECIDE.
REQ-018 DECIDE SHALL last one cycle: ones > 2^(WIN_BITS-1) -> {O_INVU,O_INVD}=2'b10; ones < 2^(WIN_BITS-1) -> 2'b01; equal -> 2'b00 (hold); the new value SHALL appear on the edge leaving DECIDE.
REQ-019 STEP SHALL be high for exactly the cycle after DECIDE when the decision is 2'b10 or 2'b01, and low for hold.
REQ-020 {O_INVU,O_INVD} SHALL never be 2'b11 and SHALL stay constant between DECIDE exits.
REQ-021 Sample and ones counters SHALL clear on entry to SAMPLE.
REQ-022 A reversal SHALL be counted when a non-hold decision differs from the previous non-hold decision; same-direction decisions SHALL reset the count to 0; hold decisions SHALL leave it unchanged.
REQ-023 Decision period SHALL be SETTLE_CYC + 2^WIN_BITS + 1 cycles (25 at defaults).

Reset
REQ-024 RST_N low SHALL immediately force state IDLE, O_INVU=0, O_INVD=0, STEP=0, BUSY=0, LOCKED=0, all counters and synchronizer flops 0.
REQ-025 Release of RST_N SHALL be honoured on the next rising CLK edge; reset mid-window SHALL discard partial counts.

Configuration
REQ-026 With CAL_LOCK_DETECT_EN defined, reaching LOCK_CNT reversals SHALL, after that DECIDE, go to DONE: LOCKED=1, outputs forced to 2'b00, no further STEP until START falls.
REQ-027 Without CAL_LOCK_DETECT_EN, LOCKED SHALL be tied 0, DONE SHALL be unreachable, and DECIDE SHALL always return to SETTLE.

Verification
REQ-028 Reset: RST_N low asynchronously mid-SAMPLE -> all outputs 0 within the same cycle, IDLE after release.
REQ-029 RAW_CMP held 1, START rises -> first {O_INVU,O_INVD}=2'b10 and STEP pulse 25 cycles after DECIDE-sequence start; repeats every 25 cycles.
REQ-030 RAW_CMP pattern giving exactly 8 ones in 16 samples -> outputs 2'b00, no STEP.
REQ-031 Lock (macro defined): RAW_CMP alternating per window 1,0,1,0,1 -> after 4th reversal LOCKED=1, outputs 2'b00, BUSY=0; macro undefined -> LOCKED stays 0, alternation continues.
REQ-032 START dropped during SETTLE -> IDLE next cycle, outputs 2'b00, reversal count cleared; START reasserted -> fresh SETTLE of 8 cycles.
